// File: rtl/dma_pkg.sv
// Shared DMA types: the descriptor handed to dma_engine plus the scheduler's
// channel id and FSM state encodings.
package dma_pkg;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [15:0] length;
    } t_dma_descriptor;

    localparam int N_SCHED_CH = 2;

    typedef logic t_sched_ch;

    typedef enum logic {
        SELECT  = 1'b0,
        PRESENT = 1'b1
    } t_sched_state;

endpackage

// File: rtl/dma_sched_queue.sv
// Register FIFO with first-word-fall-through head and a registered not_full
// flag that reflects occupancy after this cycle's push/pop.
module dma_sched_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_not_empty,
    output logic              o_not_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic              r_not_full;
    logic              w_do_push;
    logic              w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push is only taken when the registered flag said there was room.
    assign w_do_push = i_push & r_not_full;
    assign w_do_pop  = i_pop & (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_not_full <= 1'b1;
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            r_count    <= w_count_nxt;
            r_not_full <= (w_count_nxt != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head      = r_mem[r_rptr];
    assign o_not_empty = (r_count != '0);
    assign o_not_full  = r_not_full;

endmodule

// File: rtl/dma_desc_scheduler.sv
// Two-channel round-robin descriptor scheduler in front of dma_engine; caps
// descriptors in flight and routes in-order completions back by channel tag.
module dma_desc_scheduler
    import dma_pkg::*;
#(
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [N_SCHED_CH-1:0]                req_valid,
    output logic [N_SCHED_CH-1:0]                req_ready,
    input  t_dma_descriptor [N_SCHED_CH-1:0]     req_desc,
    output logic                                 descriptor_fifo_not_empty,
    output t_dma_descriptor                      descriptor,
    input  logic                                 descriptor_fifo_rdack,
    input  logic                                 desc_done,
    input  logic                                 sched_enable,
    output logic [N_SCHED_CH-1:0]                done_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 busy,
    output logic [1:0]                           err,
    output t_sched_state                         o_dbg_state
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    t_sched_state                    r_state;
    t_sched_state                    w_state_nxt;
    t_dma_descriptor [N_SCHED_CH-1:0] w_q_head;
    logic [N_SCHED_CH-1:0]           w_q_not_empty;
    logic [N_SCHED_CH-1:0]           w_q_push;
    logic [N_SCHED_CH-1:0]           w_q_pop;
    t_sched_ch                       r_last_grant;
    t_sched_ch                       w_grant_ch;
    logic                            w_grant_fire;
    logic                            w_ack;
    logic                            w_tag_head;
    logic                            w_tag_not_empty;
    logic                            w_tag_not_full;
    logic                            w_done_ok;
    t_dma_descriptor                 r_desc;
    logic [N_SCHED_CH-1:0]           r_done_valid;
    logic [1:0]                      r_err;
    logic [OW-1:0]                   r_outstanding;

    // Handshakes: a requester transfers when req_valid & req_ready in the same
    // cycle; the engine transfers the presented descriptor when rdack is high
    // while descriptor_fifo_not_empty is high, and the descriptor never
    // changes while it is presented.
    assign w_ack     = descriptor_fifo_rdack & (r_state == PRESENT);
    assign w_done_ok = desc_done & w_tag_not_empty;

    for (genvar c = 0; c < N_SCHED_CH; c++) begin : g_q
        assign w_q_push[c] = req_valid[c] & req_ready[c];
        // The channel being presented is always the one recorded as last grant.
        assign w_q_pop[c]  = w_ack & (r_last_grant == 1'(c));

        dma_sched_queue #(
            .DATA_W ($bits(t_dma_descriptor)),
            .DEPTH  (QUEUE_DEPTH)
        ) u_desc_q (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_push      (w_q_push[c]),
            .i_data      (req_desc[c]),
            .i_pop       (w_q_pop[c]),
            .o_head      (w_q_head[c]),
            .o_not_empty (w_q_not_empty[c]),
            .o_not_full  (req_ready[c])
        );
    end

    dma_sched_queue #(
        .DATA_W (1),
        .DEPTH  (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_ack),
        .i_data      (r_last_grant),
        .i_pop       (w_done_ok),
        .o_head      (w_tag_head),
        .o_not_empty (w_tag_not_empty),
        .o_not_full  (w_tag_not_full)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        if (&w_q_not_empty) begin
            w_grant_ch = ~r_last_grant;
        end else begin
            w_grant_ch = w_q_not_empty[1];
        end
        case (r_state)
            SELECT: begin
                if (sched_enable && (r_outstanding < OW'(MAX_OUTSTANDING)) &&
                    w_tag_not_full && (|w_q_not_empty)) begin
                    w_grant_fire = 1'b1;
                    w_state_nxt  = PRESENT;
                end
            end
            PRESENT: begin
                if (descriptor_fifo_rdack) w_state_nxt = SELECT;
            end
            default: w_state_nxt = SELECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= SELECT;
            r_last_grant  <= 1'b1;
            r_desc        <= '0;
            r_done_valid  <= '0;
            r_err         <= '0;
            r_outstanding <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_fire) begin
                r_desc       <= w_q_head[w_grant_ch];
                r_last_grant <= w_grant_ch;
            end
            r_done_valid <= '0;
            if (w_done_ok) r_done_valid[w_tag_head] <= 1'b1;
            r_err <= r_err | {descriptor_fifo_rdack & ~w_ack, desc_done & ~w_tag_not_empty};
            if (w_ack && !w_done_ok) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (w_done_ok && !w_ack) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
        end
    end

    assign descriptor_fifo_not_empty = (r_state == PRESENT);
    assign descriptor  = r_desc;
    assign done_valid  = r_done_valid;
    assign outstanding = r_outstanding;
    assign err         = r_err;
    assign busy        = (|w_q_not_empty) | (r_state == PRESENT) | (r_outstanding != '0);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Directed bench for dma_desc_scheduler: a cycle table for single-channel flow
// plus hand-written sequences for arbitration, limits, errors and reset.
module tb_dma_desc_scheduler;
    import dma_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [1:0]                req_valid = '0;
    logic [1:0]                req_ready;
    t_dma_descriptor [1:0]     req_desc = '0;
    logic                      descriptor_fifo_not_empty;
    t_dma_descriptor           descriptor;
    logic                      rdack = 1'b0;
    logic                      desc_done = 1'b0;
    logic                      sched_enable = 1'b1;
    logic [1:0]                done_valid;
    logic [3:0]                outstanding;
    logic                      busy;
    logic [1:0]                err;
    t_sched_state              dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dma_desc_scheduler #(.QUEUE_DEPTH(4), .MAX_OUTSTANDING(8)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .req_valid                 (req_valid),
        .req_ready                 (req_ready),
        .req_desc                  (req_desc),
        .descriptor_fifo_not_empty (descriptor_fifo_not_empty),
        .descriptor                (descriptor),
        .descriptor_fifo_rdack     (rdack),
        .desc_done                 (desc_done),
        .sched_enable              (sched_enable),
        .done_valid                (done_valid),
        .outstanding               (outstanding),
        .busy                      (busy),
        .err                       (err),
        .o_dbg_state               (dbg_state)
    );

    typedef struct {
        logic [1:0] valid;
        logic [7:0] id0;
        logic       rdack;
        logic       done;
        logic       exp_present;
        logic [7:0] exp_id;
        logic [1:0] exp_done;
        logic [3:0] exp_out;
        logic       exp_busy;
        logic [1:0] exp_ready;
    } vec_t;

    vec_t vecs[12];

    function automatic t_dma_descriptor mk(input logic [7:0] id);
        t_dma_descriptor d;
        d.src_addr = {4{id}};
        d.dst_addr = {24'h0, id} << 4;
        d.length   = {8'h0, id};
        return d;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rdack     = 1'b0;
        desc_done = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_present(input int limit);
        for (int w = 0; w < limit && !descriptor_fifo_not_empty; w++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n_got;
        int         n_push;
        int         n_ack;
        logic [7:0] got [8];
        logic [7:0] exp4 [5];

        // cycle table: inputs for one cycle, outputs expected right after its edge
        vecs[0]  = '{2'b01, 8'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 4'd0, 1'b1, 2'b11};
        vecs[1]  = '{2'b01, 8'd2, 1'b0, 1'b0, 1'b1, 8'd1, 2'b00, 4'd0, 1'b1, 2'b11};
        vecs[2]  = '{2'b01, 8'd3, 1'b1, 1'b0, 1'b0, 8'd1, 2'b00, 4'd1, 1'b1, 2'b11};
        vecs[3]  = '{2'b00, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 2'b00, 4'd1, 1'b1, 2'b11};
        vecs[4]  = '{2'b00, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2, 2'b00, 4'd2, 1'b1, 2'b11};
        vecs[5]  = '{2'b00, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 2'b00, 4'd2, 1'b1, 2'b11};
        vecs[6]  = '{2'b00, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 2'b00, 4'd3, 1'b1, 2'b11};
        vecs[7]  = '{2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3, 2'b00, 4'd3, 1'b1, 2'b11};
        vecs[8]  = '{2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 8'd3, 2'b01, 4'd2, 1'b1, 2'b11};
        vecs[9]  = '{2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 8'd3, 2'b01, 4'd1, 1'b1, 2'b11};
        vecs[10] = '{2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 8'd3, 2'b01, 4'd0, 1'b0, 2'b11};
        vecs[11] = '{2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3, 2'b00, 4'd0, 1'b0, 2'b11};

        // reset values while reset is held
        tick();
        check("rst req_ready", req_ready, 2'b11);
        check("rst present", descriptor_fifo_not_empty, 1'b0);
        check("rst descriptor", descriptor, '0);
        check("rst done_valid", done_valid, 2'b00);
        check("rst outstanding", outstanding, 4'd0);
        check("rst busy", busy, 1'b0);
        check("rst err", err, 2'b00);
        check("rst state", dbg_state, SELECT);
        reset_n = 1'b1;
        tick();

        // channel 0 only: A,B,C with immediate rdack, then three completions
        for (int i = 0; i < 12; i++) begin
            req_valid   = vecs[i].valid;
            req_desc[0] = mk(vecs[i].id0);
            req_desc[1] = '0;
            rdack       = vecs[i].rdack;
            desc_done   = vecs[i].done;
            tick();
            check($sformatf("t1[%0d] present", i), descriptor_fifo_not_empty, vecs[i].exp_present);
            check($sformatf("t1[%0d] descriptor", i), descriptor, mk(vecs[i].exp_id));
            check($sformatf("t1[%0d] done_valid", i), done_valid, vecs[i].exp_done);
            check($sformatf("t1[%0d] outstanding", i), outstanding, vecs[i].exp_out);
            check($sformatf("t1[%0d] busy", i), busy, vecs[i].exp_busy);
            check($sformatf("t1[%0d] req_ready", i), req_ready, vecs[i].exp_ready);
        end
        rdack = 1'b0;
        desc_done = 1'b0;
        check("t1 err", err, 2'b00);

        // both channels loaded with four each: grants alternate starting at 0
        do_reset();
        n_got = 0;
        for (int cyc = 0; cyc < 60 && n_got < 8; cyc++) begin
            if (cyc < 4) begin
                req_valid   = 2'b11;
                req_desc[0] = mk(8'(8'h10 + cyc));
                req_desc[1] = mk(8'(8'h20 + cyc));
            end else begin
                req_valid = 2'b00;
            end
            rdack = descriptor_fifo_not_empty;
            if (rdack) begin
                got[n_got] = descriptor.src_addr[7:0];
                n_got++;
            end
            tick();
        end
        rdack = 1'b0;
        req_valid = 2'b00;
        check("rr ack count", n_got, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr grant[%0d]", k), got[k],
                  (k % 2 == 0) ? 8'(8'h10 + k / 2) : 8'(8'h20 + k / 2));
        end
        tick();
        check("rr outstanding full", outstanding, 4'd8);
        check("rr present at limit", descriptor_fifo_not_empty, 1'b0);
        desc_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rr done[%0d]", k), done_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        desc_done = 1'b0;
        tick();
        check("rr done idle", done_valid, 2'b00);
        check("rr outstanding drained", outstanding, 4'd0);
        check("rr busy idle", busy, 1'b0);

        // outstanding limit: nine offered, eight accepted until a completion
        do_reset();
        n_push = 0;
        n_ack  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            req_valid[0] = (n_push < 9) && req_ready[0];
            req_desc[0]  = mk(8'(8'h30 + n_push));
            if (req_valid[0]) n_push++;
            rdack = descriptor_fifo_not_empty;
            if (rdack) n_ack++;
            tick();
        end
        req_valid = 2'b00;
        rdack = 1'b0;
        check("lim ack count", n_ack, 8);
        check("lim outstanding", outstanding, 4'd8);
        check("lim present held off", descriptor_fifo_not_empty, 1'b0);
        desc_done = 1'b1;
        tick();
        desc_done = 1'b0;
        check("lim done pulse", done_valid, 2'b01);
        check("lim outstanding dec", outstanding, 4'd7);
        check("lim present K+1", descriptor_fifo_not_empty, 1'b0);
        tick();
        check("lim present K+2", descriptor_fifo_not_empty, 1'b1);
        check("lim ninth desc", descriptor, mk(8'h38));

        // rdack+done together at outstanding 5, then error flags
        do_reset();
        sched_enable = 1'b0;
        req_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            req_desc[1] = mk(8'(8'h40 + k));
            tick();
        end
        check("fill ch1 ready", req_ready, 2'b01);
        req_valid = 2'b01;
        for (int k = 0; k < 2; k++) begin
            req_desc[0] = mk(8'(8'h44 + k));
            tick();
        end
        req_valid = 2'b00;
        sched_enable = 1'b1;
        exp4 = '{8'h44, 8'h40, 8'h45, 8'h41, 8'h42};
        n_ack = 0;
        for (int cyc = 0; cyc < 40 && n_ack < 5; cyc++) begin
            rdack = descriptor_fifo_not_empty;
            if (rdack) begin
                check($sformatf("mix grant[%0d]", n_ack), descriptor, mk(exp4[n_ack]));
                n_ack++;
            end
            tick();
        end
        rdack = 1'b0;
        check("mix ready after pops", req_ready, 2'b11);
        wait_present(10);
        check("mix sixth present", descriptor_fifo_not_empty, 1'b1);
        check("mix sixth desc", descriptor, mk(8'h43));
        check("mix outstanding 5", outstanding, 4'd5);
        rdack = 1'b1;
        desc_done = 1'b1;
        tick();
        rdack = 1'b0;
        check("both outstanding", outstanding, 4'd5);
        check("both done ch", done_valid, 2'b01);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("mix drain[%0d]", k), done_valid, (k == 1) ? 2'b01 : 2'b10);
        end
        desc_done = 1'b0;
        tick();
        check("mix drained", outstanding, 4'd0);
        check("mix err clean", err, 2'b00);
        desc_done = 1'b1;
        tick();
        desc_done = 1'b0;
        check("stray done pulse", done_valid, 2'b00);
        check("stray done err", err, 2'b01);
        check("stray done outstanding", outstanding, 4'd0);
        rdack = 1'b1;
        tick();
        rdack = 1'b0;
        check("stray rdack err", err, 2'b11);
        check("stray rdack outstanding", outstanding, 4'd0);
        tick();
        check("err sticky", err, 2'b11);

        // sched_enable dropped while presenting, then async reset mid-stream
        do_reset();
        check("err cleared by reset", err, 2'b00);
        req_valid = 2'b01;
        req_desc[0] = mk(8'h50);
        tick();
        req_desc[0] = mk(8'h51);
        tick();
        req_valid = 2'b00;
        wait_present(10);
        sched_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold present[%0d]", k), descriptor_fifo_not_empty, 1'b1);
            check($sformatf("hold desc[%0d]", k), descriptor, mk(8'h50));
        end
        rdack = 1'b1;
        tick();
        rdack = 1'b0;
        check("hold acked outstanding", outstanding, 4'd1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("disabled idle[%0d]", k), descriptor_fifo_not_empty, 1'b0);
            tick();
        end
        sched_enable = 1'b1;
        tick();
        check("reenable present", descriptor_fifo_not_empty, 1'b1);
        check("reenable desc", descriptor, mk(8'h51));
        #2;
        reset_n = 1'b0;
        #1;
        check("async present", descriptor_fifo_not_empty, 1'b0);
        check("async outstanding", outstanding, 4'd0);
        check("async busy", busy, 1'b0);
        check("async descriptor", descriptor, '0);
        check("async ready", req_ready, 2'b11);
        check("async state", dbg_state, SELECT);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post reset ready", req_ready, 2'b11);
        check("post reset present", descriptor_fifo_not_empty, 1'b0);
        check("post reset done", done_valid, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
